// File: rtl/ws2812_pkg.sv
// ws2812 streamer shared types and defaults.
// Timing defaults assume a 50 MHz clock.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    SEND,
    LATCH
  } state_t;

  localparam int BITS_PER_LED = 24;

  localparam int DEF_MAX_POS   = 16;
  localparam int DEF_T0H       = 20;
  localparam int DEF_T1H       = 40;
  localparam int DEF_BIT       = 63;
  localparam int DEF_RESET     = 3000;
  localparam int DEF_PREFETCH  = 2;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ws2812_frame_streamer_if.sv
// Pixel fetch bus between the streamer and the core.
// The streamer drives the index, the core returns GRB.
interface ws2812_frame_streamer_if #(
  parameter int LED_W = 4
);

  logic [LED_W-1:0] current_led;
  logic [7:0]       led_green_intensity;
  logic [7:0]       led_red_intensity;
  logic [7:0]       led_blue_intensity;

  modport master (
    output current_led,
    input  led_green_intensity,
    input  led_red_intensity,
    input  led_blue_intensity
  );

  modport slave (
    input  current_led,
    output led_green_intensity,
    output led_red_intensity,
    output led_blue_intensity
  );

endinterface

// File: rtl/ws2812_bit_encoder.sv
// One WS2812 bit period: counter plus T0H/T1H compare.
// start begins a new bit; bit_done flags its last cycle.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H_CYCLES = DEF_T0H,
  parameter int T1H_CYCLES = DEF_T1H,
  parameter int BIT_CYCLES = DEF_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_val,
  output logic data_out,
  output logic bit_done
);

  localparam int BW = width_of(BIT_CYCLES);

  logic [BW-1:0] cnt_q, cnt_d, thr;
  logic          val_q, val_d;
  logic          act_q, act_d;
  logic          out_d;

  assign bit_done = act_q && (cnt_q == BW'(BIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    val_d = val_q;
    act_d = act_q;
    if (start) begin
      cnt_d = '0;
      val_d = bit_val;
      act_d = 1'b1;
    end else if (bit_done || !act_q) begin
      cnt_d = '0;
      act_d = 1'b0;
    end
    thr   = val_d ? BW'(T1H_CYCLES) : BW'(T0H_CYCLES);
    // line level is precomputed so data_out stays a flop
    out_d = act_d && (cnt_d < thr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      val_q    <= 1'b0;
      act_q    <= 1'b0;
      data_out <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      act_q    <= act_d;
      data_out <= out_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_streamer.sv
// Scans the core's pixels and streams them as WS2812 frames.
// current_led runs one LED ahead so LED words follow gap-free.
module ws2812_frame_streamer
  import ws2812_pkg::*;
#(
  parameter int MAX_POS         = DEF_MAX_POS,
  parameter int T0H_CYCLES      = DEF_T0H,
  parameter int T1H_CYCLES      = DEF_T1H,
  parameter int BIT_CYCLES      = DEF_BIT,
  parameter int RESET_CYCLES    = DEF_RESET,
  parameter int PREFETCH_CYCLES = DEF_PREFETCH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic update_frame,
  ws2812_frame_streamer_if.master pix,
  output logic data_out,
  output logic busy,
  output logic frame_done
);

  localparam int LW = width_of(MAX_POS);
  localparam int CW = width_of(
    max3(BIT_CYCLES, RESET_CYCLES, PREFETCH_CYCLES));

  localparam logic [LW-1:0] LAST = LW'(MAX_POS - 1);
  localparam logic [LW-1:0] FIRST_NEXT =
    (MAX_POS > 1) ? LW'(1) : LW'(0);

  state_t        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   sh_q, sh_d, px;
  logic [4:0]    bi_q, bi_d;
  logic [LW-1:0] li_q, li_d;
  logic [LW-1:0] cl_q, cl_d;
  logic          pend_q, pend_d;
  logic          busy_d, fd_d;
  logic          start, bit_val, bit_done;
  int            nx;

  assign px = {pix.led_green_intensity,
               pix.led_red_intensity,
               pix.led_blue_intensity};

  assign pix.current_led = cl_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    bi_d   = bi_q;
    li_d   = li_q;
    cl_d   = cl_q;
    pend_d = pend_q;
    start  = 1'b0;
    nx     = 0;
    if (update_frame && st_q != IDLE) pend_d = 1'b1;
    unique case (st_q)
      IDLE: begin
        cl_d = '0;
        if (update_frame) begin
          st_d  = PREFETCH;
          cnt_d = '0;
        end
      end
      PREFETCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(PREFETCH_CYCLES - 1)) begin
          st_d  = SEND;
          sh_d  = px;
          li_d  = '0;
          bi_d  = 5'd23;
          cnt_d = '0;
          cl_d  = FIRST_NEXT;
          start = 1'b1;
        end
      end
      SEND: begin
        if (bit_done) begin
          if (bi_q != 5'd0) begin
            bi_d  = bi_q - 1'b1;
            start = 1'b1;
          end else if (li_q != LAST) begin
            // inputs now hold LED li_q+1; ask for the one after
            sh_d  = px;
            li_d  = li_q + 1'b1;
            bi_d  = 5'd23;
            nx    = int'(li_q) + 2;
            cl_d  = (nx > MAX_POS - 1) ? LAST : LW'(nx);
            start = 1'b1;
          end else begin
            st_d  = LATCH;
            cnt_d = '0;
            cl_d  = '0;
          end
        end
      end
      LATCH: begin
        cnt_d = cnt_q + 1'b1;
        cl_d  = '0;
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          cnt_d = '0;
          if (pend_q || update_frame) begin
            st_d   = PREFETCH;
            pend_d = 1'b0;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
    bit_val = sh_d[bi_d];
    busy_d  = (st_d != IDLE);
    fd_d    = (st_d == LATCH) &&
              (cnt_d == CW'(RESET_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      bi_q       <= '0;
      li_q       <= '0;
      cl_q       <= '0;
      pend_q     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      bi_q       <= bi_d;
      li_q       <= li_d;
      cl_q       <= cl_d;
      pend_q     <= pend_d;
      busy       <= busy_d;
      frame_done <= fd_d;
    end
  end

  ws2812_bit_encoder #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bit_val  (bit_val),
    .data_out (data_out),
    .bit_done (bit_done)
  );

endmodule
